uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler sharing the single `uart_tx` serializer among `NUM_REQ` byte-stream requesters. It grants one requester at a time for a whole message: bytes up to and including the one flagged `req_last`. A stalled owner is released by an idle timeout. The block sits between client logic and `uart_tx_inst`, driving its `tx_valid`/`tx_data` and consuming its `tx_ready`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 1024, owner-idle cycles before forced release (≥2)
- `HDR_BASE`, 8'h30, header byte base (used only with `UART_SCHED_HDR_EN`)

- `clk` in 1, system clock
- `rst` in 1, synchronous active-high reset
- `req_valid` in NUM_REQ, per-requester byte valid
- `req_data` in 8*NUM_REQ, byte of requester i at [8i+7:8i]
- `req_last` in NUM_REQ, byte is last of message
- `req_ready` out NUM_REQ, byte accepted when `req_valid[i] & req_ready[i]`
- `tx_valid` out 1, to `uart_tx`
- `tx_data` out 8, to `uart_tx`
- `tx_ready` in 1, from `uart_tx`
- `busy` out 1, grant held (state ≠ IDLE)
- `grant_id` out clog2(NUM_REQ), current/last owner
- `timeout_pulse` out 1, one-cycle pulse on forced release

## Operation
- Serializer transfer: `tx_valid & tx_ready` in the same cycle.
- Requesters must hold `req_data`/`req_last` stable while `req_valid` is high and `req_ready` is low.
- States:
  - IDLE: `tx_valid`=0 and `req_ready`=0.
    - If any `req_valid` is set, pick the first set bit scanning from `ptr+1` upward with wrap. Register it in `grant_id` and go to STREAM (or HDR when `UART_SCHED_HDR_EN` is defined).
  - HDR: `tx_valid`=1, `tx_data`=`HDR_BASE+grant_id`, `req_ready`=0. On transfer, go to STREAM.
  - STREAM: combinational pass-through for the owner g:
    - `tx_valid`=`req_valid[g]`, `tx_data`=byte g, `req_ready[g]`=`tx_ready`.
    - All other `req_ready` bits are 0.
    - Transfer with `req_last[g]`=1: go to IDLE and set `ptr`←g.
- Timeout:
  - An 11-bit-or-wider idle counter clears on entry to STREAM and on every transfer.
  - It increments each STREAM cycle where `req_valid[g]`=0.
  - Reaching `TIMEOUT_CYCLES`: go to IDLE, set `ptr`←g, pulse `timeout_pulse`. The partial message is not terminated on the line.
  - The counter is held at 0 in HDR, since the serializer is then the only stall source.
- Requests that arrive while another requester holds the grant wait. No preemption.
- Requester deasserting `req_valid` mid-message without `last`: the grant is kept until `last` or timeout.

## Timing
- Reset values:
  - state IDLE, `ptr`=NUM_REQ-1 (so requester 0 wins first), `grant_id`=0, counter 0.
  - All outputs 0: `tx_valid`, `tx_data`, `req_ready`, `busy`, `timeout_pulse`.
- Reset is honoured in any state. Mid-message reset drops the grant with no further bytes. `uart_tx` shares `rst` and aborts its own frame.
- Arbitration latency: a request seen in IDLE at cycle n gives a STREAM/HDR output at n+1.
- Message end: the last transfer at cycle n gives IDLE at n+1. The next grant is visible at n+2, so there is a one-cycle gap between messages.
- Pass-through in STREAM adds zero latency. `tx_data` is 0 in IDLE.
- Timeout: `timeout_pulse` is high in the cycle the state returns to IDLE, `TIMEOUT_CYCLES` idle cycles after the last activity.
- Simultaneous `last` transfer and timeout-threshold cycle: the transfer wins, with no pulse.

## Configuration
- `UART_SCHED_HDR_EN` defined:
  - Each grant first sends header byte `HDR_BASE+grant_id` (requester 2 → 8'h32).
  - Inter-message gap is one cycle plus the header frame.
- Undefined: the HDR state and `HDR_BASE` logic are absent. IDLE goes directly to STREAM.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/HDR/STREAM)
  - `SCHED_HDR_BASE_DEF`=8'h30
  - `SCHED_TIMEOUT_DEF`=1024
  - id-width helper function
- Sub-module `uart_rr_pick`: combinational rotate-priority encoder (`req` vector, `ptr` → `found`, `idx`). It is reusable by other shared-resource schedulers.

## Test plan
- Reset then `req_valid`=4'b1111, all single-byte messages (`last`=1), `tx_ready` pulsed every 4 cycles → grants in order 0,1,2,3,0; each `req_ready` asserts only for its owner.
- Requester 1 sends 3 bytes 8'hA1,8'hA2,8'hA3 (last on A3) while requester 3 holds `req_valid` → all three A-bytes reach `tx_data` before any requester-3 byte; `grant_id` switches to 3 two cycles after A3 transfers.
- Owner 0 drops `req_valid` after one byte without `last`, `TIMEOUT_CYCLES`=16 → `timeout_pulse` exactly 16 idle cycles later; next grant goes to requester 1 if requesting.
- `rst` asserted mid-message in STREAM → next cycle `tx_valid`=0, `req_ready`=0, `busy`=0, `grant_id`=0; the following request from 2 and 0 together grants 0.
- With `UART_SCHED_HDR_EN`, requester 2 sends 8'h55 (`last`) → serializer sees 8'h32 then 8'h55; `req_ready[2]` stays low during the header.
- Last-byte transfer on the same cycle the idle counter would hit threshold → no `timeout_pulse`; normal return to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART package: scheduler state encoding, default parameters and an id-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM
    } sched_state_t;

    localparam logic [7:0] SCHED_HDR_BASE_DEF = 8'h30;
    localparam int         SCHED_TIMEOUT_DEF  = 1024;

    // Width of an index into n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: picks the first set bit of req scanning upward from ptr+1 with wrap.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4,
    localparam int W = id_width(N)
)(
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte-stream requesters.
// Define UART_SCHED_HDR_EN to send a header byte HDR_BASE+grant_id at the start of every grant.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEF,
`ifdef UART_SCHED_HDR_EN
    parameter logic [7:0] HDR_BASE = SCHED_HDR_BASE_DEF,
`endif
    localparam int GW = id_width(NUM_REQ)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 timeout_pulse
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 11) ? $clog2(TIMEOUT_CYCLES + 1) : 11;

    sched_state_t  state;
    logic [GW-1:0] ptr;
    logic [CW-1:0] idle_cnt;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [7:0]    req_bytes [NUM_REQ];
    logic          xfer;

    uart_rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // The owner's stream is passed straight through so STREAM adds no latency.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (state)
`ifdef UART_SCHED_HDR_EN
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BASE + 8'(grant_id);
            end
`endif
            STREAM: begin
                tx_valid            = req_valid[grant_id];
                tx_data             = req_bytes[grant_id];
                req_ready[grant_id] = tx_ready;
            end
            default: ;
        endcase
    end

    assign xfer = tx_valid & tx_ready;
    assign busy = (state != IDLE);

    // A last-byte transfer is checked before the idle threshold, so it wins without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= GW'(NUM_REQ - 1);
            grant_id      <= '0;
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        idle_cnt <= '0;
`ifdef UART_SCHED_HDR_EN
                        state    <= HDR;
`else
                        state    <= STREAM;
`endif
                    end
                end
`ifdef UART_SCHED_HDR_EN
                HDR: begin
                    idle_cnt <= '0;
                    if (xfer) begin
                        state <= STREAM;
                    end
                end
`endif
                STREAM: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (req_last[grant_id]) begin
                            state <= IDLE;
                            ptr   <= grant_id;
                        end
                    end else if (!req_valid[grant_id]) begin
                        if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            state         <= IDLE;
                            ptr           <= grant_id;
                            idle_cnt      <= '0;
                            timeout_pulse <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
